safety_lockstep_ctrl: RTL and testbench

SAFETY_LOCKSTEP_CTRL -- requirements
Module: safety_lockstep_ctrl

---
 rtl/safety_lockstep_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_safety_lockstep_ctrl.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/safety_lockstep_ctrl.sv
// Lockstep voter that merges the data ports of 2 (DMR) or 3 (TMR) redundant cores onto one memory port.
// Define SAFETY_LOCKSTEP_SKEW_TOL_EN to tolerate up to MaxSkew cycles of request skew between cores.
module safety_lockstep_ctrl #(
   parameter int NumCores = 2,
   parameter int MaxSkew  = 4,
   parameter int CntWidth = 8
) (
   input  logic                      clk_i,
   input  logic                      rst_i,
   input  logic [NumCores-1:0]       core_req_i,
   input  logic [NumCores-1:0]       core_we_i,
   input  logic [NumCores-1:0][3:0]  core_be_i,
   input  logic [NumCores-1:0][31:0] core_addr_i,
   input  logic [NumCores-1:0][31:0] core_wdata_i,
   output logic [NumCores-1:0]       core_gnt_o,
   output logic                      core_rvalid_o,
   output logic [31:0]               core_rdata_o,
   output logic                      mem_req_o,
   input  logic                      mem_gnt_i,
   output logic                      mem_we_o,
   output logic [3:0]                mem_be_o,
   output logic [31:0]               mem_addr_o,
   output logic [31:0]               mem_wdata_o,
   input  logic                      mem_rvalid_i,
   input  logic [31:0]               mem_rdata_i,
   output logic                      fatal_o,
   output logic [NumCores-1:0]       faulty_core_o,
   output logic                      resync_req_o,
   input  logic                      resync_ack_i,
   input  logic                      clear_i,
   output logic [CntWidth-1:0]       mismatch_cnt_o
);

   // state     | meaning
   // ST_RUN    | all cores agree, majority requests forwarded
   // ST_RESYNC | one core outvoted; majority still forwarded, waiting for resync_ack_i
   // ST_FATAL  | no majority; memory port blocked until clear_i
   typedef enum logic [1:0] {ST_RUN, ST_RESYNC, ST_FATAL} state_t;

   if (NumCores != 2 && NumCores != 3) begin : g_bad_cores
      $error("safety_lockstep_ctrl: NumCores must be 2 (DMR) or 3 (TMR)");
   end
   if (MaxSkew < 0) begin : g_bad_skew
      $error("safety_lockstep_ctrl: MaxSkew must not be negative");
   end

   state_t              state, state_nxt;
   logic                outstanding, outstanding_nxt;
   logic [NumCores-1:0] faulty, faulty_nxt;
   logic [CntWidth-1:0] cnt, cnt_nxt;

   logic [69:0]         key [NumCores];
   logic [69:0]         maj_key;
   logic                maj_ok;
   logic [NumCores-1:0] odd;
   logic                window, any_req, all_req, partial, hold;
   logic                eval, fwd, single, nomaj;

   // A non-requesting core votes with an all-zero key, so partial requests
   // split the cores into a requesting and a non-requesting group.
   always_comb begin
      for (int i = 0; i < NumCores; i++) begin
         key[i] = core_req_i[i]
                  ? {1'b1, core_we_i[i], core_be_i[i], core_addr_i[i], core_wdata_i[i]}
                  : '0;
      end
   end

   always_comb begin
      maj_key = key[0];
      maj_ok  = 1'b0;
      odd     = '0;
      if (NumCores == 2) begin
         maj_ok = (key[0] == key[1]);
      end else if (key[0] == key[1]) begin
         maj_ok              = 1'b1;
         odd[NumCores-1]     = (key[0] != key[NumCores-1]);
      end else if (key[0] == key[NumCores-1]) begin
         maj_ok = 1'b1;
         odd[1] = 1'b1;
      end else if (key[1] == key[NumCores-1]) begin
         maj_ok  = 1'b1;
         odd[0]  = 1'b1;
         maj_key = key[1];
      end
   end

   assign window  = (state != ST_FATAL) && !outstanding;
   assign any_req = |core_req_i;
   assign all_req = &core_req_i;
   assign partial = any_req && !all_req;

`ifdef SAFETY_LOCKSTEP_SKEW_TOL_EN
   localparam int SkewW = (MaxSkew < 1) ? 1 : $clog2(MaxSkew + 1);
   localparam logic [SkewW-1:0] SkewLoad = SkewW'(MaxSkew);

   logic [SkewW-1:0] skew_left;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         skew_left <= SkewLoad;
      end else if (!(window && partial)) begin
         skew_left <= SkewLoad;
      end else if (skew_left != '0) begin
         skew_left <= skew_left - SkewW'(1);
      end
   end

   // Partial requests are only judged on the cycle the skew budget runs out.
   assign hold = window && partial && (skew_left != '0);
`else
   assign hold = 1'b0;
`endif

   assign eval   = window && any_req && !hold;
   assign fwd    = eval && maj_ok && maj_key[69];
   assign single = eval && maj_ok && (|odd);
   assign nomaj  = eval && !maj_ok;

   assign mem_req_o      = fwd && !rst_i;
   assign {mem_we_o, mem_be_o, mem_addr_o, mem_wdata_o} = mem_req_o ? maj_key[68:0] : '0;
   assign core_gnt_o     = {NumCores{mem_req_o && mem_gnt_i}};
   assign core_rvalid_o  = mem_rvalid_i && !rst_i;
   assign core_rdata_o   = rst_i ? '0 : mem_rdata_i;
   assign fatal_o        = (state == ST_FATAL);
   assign resync_req_o   = (state == ST_RESYNC);
   assign faulty_core_o  = faulty;
   assign mismatch_cnt_o = cnt;

   always_comb begin
      state_nxt       = state;
      faulty_nxt      = faulty;
      cnt_nxt         = cnt;
      outstanding_nxt = outstanding;

      if (mem_rvalid_i) begin
         outstanding_nxt = 1'b0;
      end else if (mem_req_o && mem_gnt_i) begin
         outstanding_nxt = 1'b1;
      end

      if ((single || nomaj) && (cnt != '1)) begin
         cnt_nxt = cnt + CntWidth'(1);
      end

      case (state)
         ST_FATAL: begin
            if (clear_i) begin
               state_nxt  = ST_RUN;
               faulty_nxt = '0;
            end
         end
         default: begin
            // A fresh disagreement outranks a coincident resync acknowledge.
            if (nomaj) begin
               state_nxt = ST_FATAL;
            end else if (single) begin
               state_nxt  = ST_RESYNC;
               faulty_nxt = odd;
            end else if ((state == ST_RESYNC) && resync_ack_i) begin
               state_nxt  = ST_RUN;
               faulty_nxt = '0;
            end
         end
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state       <= ST_RUN;
         outstanding <= 1'b0;
         faulty      <= '0;
         cnt         <= '0;
      end else begin
         state       <= state_nxt;
         outstanding <= outstanding_nxt;
         faulty      <= faulty_nxt;
         cnt         <= cnt_nxt;
      end
   end

endmodule

// File: tb/tb_safety_lockstep_ctrl.sv
// Self-checking bench for safety_lockstep_ctrl: one DMR and one TMR instance, scoreboarded read data.
module tb_safety_lockstep_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   // DMR instance signals
   logic [1:0]       d_req, d_we, d_gnt, d_faulty;
   logic [1:0][3:0]  d_be;
   logic [1:0][31:0] d_addr, d_wdata;
   logic             d_rvalid, d_mreq, d_mgnt, d_mwe, d_mrvalid, d_fatal, d_rsreq, d_rsack, d_clear;
   logic [31:0]      d_rdata, d_maddr, d_mwdata, d_mrdata;
   logic [3:0]       d_mbe;
   logic [7:0]       d_cnt;

   // TMR instance signals
   logic [2:0]       t_req, t_we, t_gnt, t_faulty;
   logic [2:0][3:0]  t_be;
   logic [2:0][31:0] t_addr, t_wdata;
   logic             t_rvalid, t_mreq, t_mgnt, t_mwe, t_mrvalid, t_fatal, t_rsreq, t_rsack, t_clear;
   logic [31:0]      t_rdata, t_maddr, t_mwdata, t_mrdata;
   logic [3:0]       t_mbe;
   logic [7:0]       t_cnt;

   logic [31:0] exp_q [$];
   int          n_assert = 0;
   int          n_fail   = 0;
   int          d_exp_cnt = 0;
   int          t_exp_cnt = 0;

   safety_lockstep_ctrl #(.NumCores(2), .MaxSkew(4), .CntWidth(8)) u_dmr (
      .clk_i(clk), .rst_i(rst),
      .core_req_i(d_req), .core_we_i(d_we), .core_be_i(d_be), .core_addr_i(d_addr),
      .core_wdata_i(d_wdata), .core_gnt_o(d_gnt), .core_rvalid_o(d_rvalid), .core_rdata_o(d_rdata),
      .mem_req_o(d_mreq), .mem_gnt_i(d_mgnt), .mem_we_o(d_mwe), .mem_be_o(d_mbe),
      .mem_addr_o(d_maddr), .mem_wdata_o(d_mwdata), .mem_rvalid_i(d_mrvalid), .mem_rdata_i(d_mrdata),
      .fatal_o(d_fatal), .faulty_core_o(d_faulty), .resync_req_o(d_rsreq), .resync_ack_i(d_rsack),
      .clear_i(d_clear), .mismatch_cnt_o(d_cnt)
   );

   safety_lockstep_ctrl #(.NumCores(3), .MaxSkew(4), .CntWidth(8)) u_tmr (
      .clk_i(clk), .rst_i(rst),
      .core_req_i(t_req), .core_we_i(t_we), .core_be_i(t_be), .core_addr_i(t_addr),
      .core_wdata_i(t_wdata), .core_gnt_o(t_gnt), .core_rvalid_o(t_rvalid), .core_rdata_o(t_rdata),
      .mem_req_o(t_mreq), .mem_gnt_i(t_mgnt), .mem_we_o(t_mwe), .mem_be_o(t_mbe),
      .mem_addr_o(t_maddr), .mem_wdata_o(t_mwdata), .mem_rvalid_i(t_mrvalid), .mem_rdata_i(t_mrdata),
      .fatal_o(t_fatal), .faulty_core_o(t_faulty), .resync_req_o(t_rsreq), .resync_ack_i(t_rsack),
      .clear_i(t_clear), .mismatch_cnt_o(t_cnt)
   );

   task automatic test_reset();
      rst = 1'b1;
      @(negedge clk);
      @(negedge clk);
      n_assert++; if (d_mreq !== 1'b0) begin n_fail++; $display("FAIL rst_d_mreq got=%0h exp=0", d_mreq); end
      n_assert++; if (d_cnt !== 8'h00) begin n_fail++; $display("FAIL rst_d_cnt got=%0h exp=0", d_cnt); end
      n_assert++; if (d_fatal !== 1'b0) begin n_fail++; $display("FAIL rst_d_fatal got=%0h exp=0", d_fatal); end
      n_assert++; if (t_faulty !== 3'b000) begin n_fail++; $display("FAIL rst_t_faulty got=%0h exp=0", t_faulty); end
      n_assert++; if (t_rsreq !== 1'b0) begin n_fail++; $display("FAIL rst_t_rsreq got=%0h exp=0", t_rsreq); end
      n_assert++; if (t_gnt !== 3'b000) begin n_fail++; $display("FAIL rst_t_gnt got=%0h exp=0", t_gnt); end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_dmr_read();
      logic [31:0] e;
      d_req = 2'b11; d_we = 2'b00; d_be = '1; d_addr = {32'h100, 32'h100}; d_wdata = '0; d_mgnt = 1'b1;
      exp_q.push_back(32'h0000CAFE);
      #1;
      n_assert++; if (d_mreq !== 1'b1) begin n_fail++; $display("FAIL dmr_rd_req got=%0h exp=1", d_mreq); end
      n_assert++; if (d_maddr !== 32'h100) begin n_fail++; $display("FAIL dmr_rd_addr got=%0h exp=100", d_maddr); end
      n_assert++; if (d_gnt !== 2'b11) begin n_fail++; $display("FAIL dmr_rd_gnt got=%0h exp=3", d_gnt); end
      @(negedge clk);
      d_mgnt = 1'b0;
      #1;
      n_assert++; if (d_mreq !== 1'b0) begin n_fail++; $display("FAIL dmr_outstanding_blocks got=%0h exp=0", d_mreq); end
      @(negedge clk);
      d_req = 2'b00; d_mrvalid = 1'b1; d_mrdata = 32'h0000CAFE;
      #1;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
      n_assert++; if (d_rvalid !== 1'b1) begin n_fail++; $display("FAIL dmr_rd_rvalid got=%0h exp=1", d_rvalid); end
      n_assert++; if (d_rdata !== e) begin n_fail++; $display("FAIL dmr_rd_rdata got=%0h exp=%0h", d_rdata, e); end
      @(negedge clk);
      d_mrvalid = 1'b0;
      n_assert++; if (d_cnt !== 8'(d_exp_cnt)) begin n_fail++; $display("FAIL dmr_rd_cnt got=%0h exp=%0h", d_cnt, d_exp_cnt); end
   endtask

   task automatic test_tmr_single();
      logic [31:0] e;
      t_req = 3'b111; t_we = 3'b111; t_be = '1; t_addr = {32'h40, 32'h40, 32'h40};
      t_wdata = {32'h1, 32'h0, 32'h0}; t_mgnt = 1'b1;
      exp_q.push_back(32'h0);
      #1;
      n_assert++; if (t_mreq !== 1'b1) begin n_fail++; $display("FAIL tmr1_req got=%0h exp=1", t_mreq); end
      n_assert++; if (t_mwdata !== 32'h0) begin n_fail++; $display("FAIL tmr1_wdata got=%0h exp=0", t_mwdata); end
      n_assert++; if (t_gnt !== 3'b111) begin n_fail++; $display("FAIL tmr1_gnt got=%0h exp=7", t_gnt); end
      @(negedge clk);
      t_req = '0; t_mgnt = 1'b0; t_mrvalid = 1'b1; t_mrdata = 32'h0;
      t_exp_cnt = t_exp_cnt + 1;
      #1;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
      n_assert++; if (t_faulty !== 3'b100) begin n_fail++; $display("FAIL tmr1_faulty got=%0h exp=4", t_faulty); end
      n_assert++; if (t_rsreq !== 1'b1) begin n_fail++; $display("FAIL tmr1_rsreq got=%0h exp=1", t_rsreq); end
      n_assert++; if (t_cnt !== 8'(t_exp_cnt)) begin n_fail++; $display("FAIL tmr1_cnt got=%0h exp=%0h", t_cnt, t_exp_cnt); end
      n_assert++; if (t_rdata !== e) begin n_fail++; $display("FAIL tmr1_rdata got=%0h exp=%0h", t_rdata, e); end
      @(negedge clk);
      t_mrvalid = 1'b0;
      t_req = 3'b111; t_we = '0; t_addr = {32'h80, 32'h80, 32'h80}; t_wdata = '0; t_mgnt = 1'b1;
      exp_q.push_back(32'hDEAD);
      #1;
      n_assert++; if (t_maddr !== 32'h80 || t_mreq !== 1'b1) begin n_fail++; $display("FAIL tmr_resync_fwd got=%0h/%0h exp=1/80", t_mreq, t_maddr); end
      @(negedge clk);
      t_req = '0; t_mgnt = 1'b0; t_mrvalid = 1'b1; t_mrdata = 32'hDEAD;
      #1;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
      n_assert++; if (t_rdata !== e) begin n_fail++; $display("FAIL tmr_resync_rdata got=%0h exp=%0h", t_rdata, e); end
      @(negedge clk);
      t_mrvalid = 1'b0; t_rsack = 1'b1;
      @(negedge clk);
      t_rsack = 1'b0;
      n_assert++; if (t_faulty !== 3'b000) begin n_fail++; $display("FAIL tmr_ack_faulty got=%0h exp=0", t_faulty); end
      n_assert++; if (t_rsreq !== 1'b0) begin n_fail++; $display("FAIL tmr_ack_rsreq got=%0h exp=0", t_rsreq); end
   endtask

   task automatic test_tmr_ack_collision();
      t_req = 3'b111; t_we = '0; t_addr = {32'h40, 32'h40, 32'h44}; t_wdata = '0; t_mgnt = 1'b1;
      exp_q.push_back(32'h11);
      #1;
      n_assert++; if (t_maddr !== 32'h40) begin n_fail++; $display("FAIL tmr_c0_addr got=%0h exp=40", t_maddr); end
      @(negedge clk);
      t_req = '0; t_mgnt = 1'b0; t_mrvalid = 1'b1; t_mrdata = 32'h11;
      t_exp_cnt = t_exp_cnt + 1;
      #1;
      n_assert++; if (t_faulty !== 3'b001) begin n_fail++; $display("FAIL tmr_c0_faulty got=%0h exp=1", t_faulty); end
      void'(exp_q.pop_front());
      @(negedge clk);
      t_mrvalid = 1'b0; t_rsack = 1'b1;
      t_req = 3'b111; t_we = 3'b111; t_addr = {32'h48, 32'h48, 32'h48}; t_wdata = {32'h0, 32'h5, 32'h0}; t_mgnt = 1'b1;
      exp_q.push_back(32'h22);
      #1;
      n_assert++; if (t_mwdata !== 32'h0) begin n_fail++; $display("FAIL tmr_coll_wdata got=%0h exp=0", t_mwdata); end
      @(negedge clk);
      t_rsack = 1'b0; t_req = '0; t_mgnt = 1'b0; t_mrvalid = 1'b1; t_mrdata = 32'h22;
      t_exp_cnt = t_exp_cnt + 1;
      #1;
      n_assert++; if (t_faulty !== 3'b010) begin n_fail++; $display("FAIL tmr_coll_faulty got=%0h exp=2", t_faulty); end
      n_assert++; if (t_rsreq !== 1'b1) begin n_fail++; $display("FAIL tmr_coll_rsreq got=%0h exp=1", t_rsreq); end
      n_assert++; if (t_cnt !== 8'(t_exp_cnt)) begin n_fail++; $display("FAIL tmr_coll_cnt got=%0h exp=%0h", t_cnt, t_exp_cnt); end
      void'(exp_q.pop_front());
      @(negedge clk);
      t_mrvalid = 1'b0; t_rsack = 1'b1;
      @(negedge clk);
      t_rsack = 1'b0;
   endtask

   task automatic test_tmr_nomaj();
      t_req = 3'b111; t_we = '0; t_addr = {32'h3, 32'h2, 32'h1}; t_wdata = '0; t_mgnt = 1'b1;
      #1;
      n_assert++; if (t_mreq !== 1'b0 || t_gnt !== 3'b000) begin n_fail++; $display("FAIL tmr_nomaj_block got=%0h/%0h exp=0/0", t_mreq, t_gnt); end
      @(negedge clk);
      t_req = '0; t_mgnt = 1'b0; t_mrvalid = 1'b1; t_mrdata = 32'h1234;
      t_exp_cnt = t_exp_cnt + 1;
      #1;
      n_assert++; if (t_fatal !== 1'b1) begin n_fail++; $display("FAIL tmr_nomaj_fatal got=%0h exp=1", t_fatal); end
      n_assert++; if (t_cnt !== 8'(t_exp_cnt)) begin n_fail++; $display("FAIL tmr_nomaj_cnt got=%0h exp=%0h", t_cnt, t_exp_cnt); end
      n_assert++; if (t_rvalid !== 1'b1 || t_rdata !== 32'h1234) begin n_fail++; $display("FAIL tmr_fatal_rsp got=%0h/%0h exp=1/1234", t_rvalid, t_rdata); end
      @(negedge clk);
      t_mrvalid = 1'b0; t_clear = 1'b1;
      @(negedge clk);
      t_clear = 1'b0;
      n_assert++; if (t_fatal !== 1'b0) begin n_fail++; $display("FAIL tmr_clear_fatal got=%0h exp=0", t_fatal); end
   endtask

   task automatic test_dmr_fatal();
      d_req = 2'b11; d_we = '0; d_addr = {32'h14, 32'h10}; d_wdata = '0; d_mgnt = 1'b1;
      #1;
      n_assert++; if (d_mreq !== 1'b0 || d_gnt !== 2'b00) begin n_fail++; $display("FAIL dmr_fatal_block got=%0h/%0h exp=0/0", d_mreq, d_gnt); end
      @(negedge clk);
      d_mgnt = 1'b0; d_mrvalid = 1'b1; d_mrdata = 32'hBEEF;
      d_exp_cnt = d_exp_cnt + 1;
      #1;
      n_assert++; if (d_fatal !== 1'b1) begin n_fail++; $display("FAIL dmr_fatal got=%0h exp=1", d_fatal); end
      n_assert++; if (d_mreq !== 1'b0) begin n_fail++; $display("FAIL dmr_fatal_req got=%0h exp=0", d_mreq); end
      n_assert++; if (d_cnt !== 8'(d_exp_cnt)) begin n_fail++; $display("FAIL dmr_fatal_cnt got=%0h exp=%0h", d_cnt, d_exp_cnt); end
      n_assert++; if (d_rvalid !== 1'b1 || d_rdata !== 32'hBEEF) begin n_fail++; $display("FAIL dmr_fatal_rsp got=%0h/%0h exp=1/beef", d_rvalid, d_rdata); end
      @(negedge clk);
      d_req = '0; d_mrvalid = 1'b0; d_clear = 1'b1;
      @(negedge clk);
      d_clear = 1'b0;
      n_assert++; if (d_fatal !== 1'b0) begin n_fail++; $display("FAIL dmr_clear got=%0h exp=0", d_fatal); end
   endtask

   task automatic test_skew();
      logic [31:0] e;
      d_we = '0; d_addr = {32'h200, 32'h200}; d_wdata = '0; d_req = 2'b01; d_mgnt = 1'b1;
`ifdef SAFETY_LOCKSTEP_SKEW_TOL_EN
      for (int i = 0; i < 3; i++) begin
         #1;
         n_assert++; if (d_mreq !== 1'b0 || d_gnt !== 2'b00) begin n_fail++; $display("FAIL skew_hold_%0d got=%0h/%0h exp=0/0", i, d_mreq, d_gnt); end
         @(negedge clk);
      end
      d_req = 2'b11;
      exp_q.push_back(32'h5A5A);
      #1;
      n_assert++; if (d_mreq !== 1'b1 || d_gnt !== 2'b11) begin n_fail++; $display("FAIL skew_join got=%0h/%0h exp=1/3", d_mreq, d_gnt); end
      @(negedge clk);
      d_req = '0; d_mgnt = 1'b0; d_mrvalid = 1'b1; d_mrdata = 32'h5A5A;
      #1;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
      n_assert++; if (d_rdata !== e) begin n_fail++; $display("FAIL skew_rdata got=%0h exp=%0h", d_rdata, e); end
      n_assert++; if (d_fatal !== 1'b0 || d_cnt !== 8'(d_exp_cnt)) begin n_fail++; $display("FAIL skew_nofault got=%0h/%0h exp=0/%0h", d_fatal, d_cnt, d_exp_cnt); end
      @(negedge clk);
      d_mrvalid = 1'b0;
`else
      e = 32'h0;
      #1;
      n_assert++; if (d_mreq !== 1'b0 || d_gnt !== 2'b00) begin n_fail++; $display("FAIL skew_block got=%0h/%0h exp=0/0 (%0h)", d_mreq, d_gnt, e); end
      @(negedge clk);
      d_req = '0; d_mgnt = 1'b0;
      d_exp_cnt = d_exp_cnt + 1;
      #1;
      n_assert++; if (d_fatal !== 1'b1) begin n_fail++; $display("FAIL skew_fatal got=%0h exp=1", d_fatal); end
      n_assert++; if (d_cnt !== 8'(d_exp_cnt)) begin n_fail++; $display("FAIL skew_cnt got=%0h exp=%0h", d_cnt, d_exp_cnt); end
      @(negedge clk);
      d_clear = 1'b1;
      @(negedge clk);
      d_clear = 1'b0;
`endif
   endtask

   task automatic test_saturation();
      logic [31:0] e;
      for (int i = 0; i < 260; i++) begin
         t_req = 3'b111; t_we = 3'b111; t_addr = {32'h60, 32'h60, 32'h60};
         t_wdata = {32'h0, 32'h7, 32'h0}; t_mgnt = 1'b1;
         exp_q.push_back(32'(i));
         @(negedge clk);
         t_req = '0; t_mgnt = 1'b0; t_mrvalid = 1'b1; t_mrdata = 32'(i);
         t_exp_cnt = (t_exp_cnt >= 255) ? 255 : t_exp_cnt + 1;
         #1;
         e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
         n_assert++; if (t_rdata !== e) begin n_fail++; $display("FAIL sat_rdata_%0d got=%0h exp=%0h", i, t_rdata, e); end
         @(negedge clk);
         t_mrvalid = 1'b0;
      end
      n_assert++; if (t_cnt !== 8'(t_exp_cnt)) begin n_fail++; $display("FAIL sat_cnt got=%0h exp=%0h", t_cnt, t_exp_cnt); end
      t_rsack = 1'b1;
      @(negedge clk);
      t_rsack = 1'b0;
      n_assert++; if (t_cnt !== 8'hFF) begin n_fail++; $display("FAIL sat_hold got=%0h exp=ff", t_cnt); end
   endtask

   task automatic test_reset_mid();
      logic [31:0] e;
      d_req = 2'b11; d_we = '0; d_addr = {32'h300, 32'h300}; d_wdata = '0; d_mgnt = 1'b1;
      @(negedge clk);
      d_mgnt = 1'b0;
      #2;
      rst = 1'b1; d_mrvalid = 1'b1; d_mrdata = 32'h7777;
      d_exp_cnt = 0;
      #1;
      n_assert++; if (d_mreq !== 1'b0 || d_rvalid !== 1'b0 || d_rdata !== 32'h0) begin n_fail++; $display("FAIL midrst_async got=%0h/%0h/%0h exp=0/0/0", d_mreq, d_rvalid, d_rdata); end
      n_assert++; if (d_cnt !== 8'(d_exp_cnt)) begin n_fail++; $display("FAIL midrst_cnt got=%0h exp=%0h", d_cnt, d_exp_cnt); end
      n_assert++; if (t_cnt !== 8'h00 || t_faulty !== 3'b000) begin n_fail++; $display("FAIL midrst_tmr got=%0h/%0h exp=0/0", t_cnt, t_faulty); end
      @(negedge clk);
      n_assert++; if (d_fatal !== 1'b0 || d_gnt !== 2'b00) begin n_fail++; $display("FAIL midrst_edge got=%0h/%0h exp=0/0", d_fatal, d_gnt); end
      rst = 1'b0; d_mrvalid = 1'b0; d_mgnt = 1'b1;
      exp_q.push_back(32'h8888);
      #1;
      n_assert++; if (d_mreq !== 1'b1) begin n_fail++; $display("FAIL midrst_noout got=%0h exp=1", d_mreq); end
      @(negedge clk);
      d_req = '0; d_mgnt = 1'b0; d_mrvalid = 1'b1; d_mrdata = 32'h8888;
      #1;
      e = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hxxxxxxxx;
      n_assert++; if (d_rdata !== e) begin n_fail++; $display("FAIL midrst_rdata got=%0h exp=%0h", d_rdata, e); end
      @(negedge clk);
      d_mrvalid = 1'b0;
      n_assert++; if (exp_q.size() != 0) begin n_fail++; $display("FAIL sb_empty got=%0d exp=0", exp_q.size()); end
   endtask

   initial begin
      d_req = '0; d_we = '0; d_be = '1; d_addr = '0; d_wdata = '0;
      d_mgnt = 1'b0; d_mrvalid = 1'b0; d_mrdata = '0; d_rsack = 1'b0; d_clear = 1'b0;
      t_req = '0; t_we = '0; t_be = '1; t_addr = '0; t_wdata = '0;
      t_mgnt = 1'b0; t_mrvalid = 1'b0; t_mrdata = '0; t_rsack = 1'b0; t_clear = 1'b0;
      test_reset();
      test_dmr_read();
      test_tmr_single();
      test_tmr_ack_collision();
      test_tmr_nomaj();
      test_dmr_fatal();
      test_skew();
      test_saturation();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout got=running exp=finished");
      $fatal(1, "timeout");
   end

endmodule
